mu0_control: RTL and testbench

- Control unit for the MU0 16-bit datapath.
- Sequences the PC, IR and ACC registers (mu0_reg16 instances), the X/Y/address multiplexers, the ALU and the memory interface through a fetch/execute state machine.
- Supports memory wait states via a ready handshake.
- Sits beside the datapath inside the MU0 top level; decodes the 4-bit opcode IR[15:12] and the ACC status flags.

---
 rtl/mu0_control_pkg.sv | 39 +++
 rtl/mu0_decode.sv | 89 ++++++++
 rtl/mu0_control.sv | 78 +++++++
 tb/tb_mu0_control.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mu0_control_pkg.sv
// Shared definitions for the MU0 control unit: opcodes, FSM state encoding,
// ALU function codes and datapath mux select codes.
package mu0_defs;

    localparam int OPCODE_W = 4;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        HALT  = 2'b10
    } stateT;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STO = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    localparam logic [1:0] ALU_Y   = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_INC = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    localparam logic X_ACC   = 1'b0;
    localparam logic X_PC    = 1'b1;
    localparam logic Y_MEM   = 1'b0;
    localparam logic Y_IR    = 1'b1;
    localparam logic ADDR_PC = 1'b0;
    localparam logic ADDR_IR = 1'b1;

    // Instructions that occupy the memory port during EXEC and may stall on it.
    function automatic logic isMemOp(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_STO) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/mu0_decode.sv
// Combinational control decode for MU0: maps FSM state, opcode, ACC flags and
// memory ready onto datapath selects, register enables and memory strobes.
module mu0_decode
    import mu0_defs::*;
#(
    parameter int OPW = 4
) (
    input  logic           Reset,
    input  stateT          state,
    input  logic [OPW-1:0] F,
    input  logic           N,
    input  logic           Z,
    input  logic           Mem_rdy,
    output logic           X_sel,
    output logic           Y_sel,
    output logic           Addr_sel,
    output logic [1:0]     ALU_fs,
    output logic           PC_En,
    output logic           IR_En,
    output logic           Acc_En,
    output logic           Mem_req,
    output logic           Mem_wr,
    output logic           Halted
);

    logic [3:0] op;
    logic       jumpTaken;

    assign op = F[3:0];

    always_comb begin
        X_sel     = X_ACC;
        Y_sel     = Y_MEM;
        Addr_sel  = ADDR_PC;
        ALU_fs    = ALU_Y;
        PC_En     = 1'b0;
        IR_En     = 1'b0;
        Acc_En    = 1'b0;
        Mem_req   = 1'b0;
        Mem_wr    = 1'b0;
        Halted    = 1'b0;
        jumpTaken = 1'b0;

        // Reset silences every strobe so nothing is written while it is held.
        if (!Reset) begin
            case (state)
                FETCH: begin
                    Addr_sel = ADDR_PC;
                    Mem_req  = 1'b1;
                    X_sel    = X_PC;
                    ALU_fs   = ALU_INC;
                    IR_En    = Mem_rdy;
                    PC_En    = Mem_rdy;
                end
                EXEC: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            Addr_sel = ADDR_IR;
                            Mem_req  = 1'b1;
                            Y_sel    = Y_MEM;
                            X_sel    = X_ACC;
                            ALU_fs   = (op == OP_LDA) ? ALU_Y :
                                       (op == OP_ADD) ? ALU_ADD : ALU_SUB;
                            Acc_En   = Mem_rdy;
                        end
                        OP_STO: begin
                            Addr_sel = ADDR_IR;
                            Mem_req  = 1'b1;
                            Mem_wr   = 1'b1;
                        end
                        OP_JMP:  jumpTaken = 1'b1;
                        OP_JGE:  jumpTaken = !N;
                        OP_JNE:  jumpTaken = !Z;
                        default: ;
                    endcase
                    // A not-taken branch leaves the selects at their idle zeros.
                    if (jumpTaken) begin
                        Y_sel  = Y_IR;
                        ALU_fs = ALU_Y;
                        PC_En  = 1'b1;
                    end
                end
                HALT:    Halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mu0_control.sv
// MU0 control unit: fetch/execute state register with memory wait-state
// handling; output decoding lives in mu0_decode.
module mu0_control
    import mu0_defs::*;
#(
    parameter int OPW = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic [OPW-1:0] F,
    input  logic           N,
    input  logic           Z,
    input  logic           Mem_rdy,
    output logic           X_sel,
    output logic           Y_sel,
    output logic           Addr_sel,
    output logic [1:0]     ALU_fs,
    output logic           PC_En,
    output logic           IR_En,
    output logic           Acc_En,
    output logic           Mem_req,
    output logic           Mem_wr,
    output logic           Halted
);

    stateT state;
    stateT stateNext;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= FETCH;
        end else begin
            state <= stateNext;
        end
    end

    // Memory instructions hold EXEC until the access completes; HALT is only
    // left through Reset.
    always_comb begin
        stateNext = state;
        case (state)
            FETCH: stateNext = Mem_rdy ? EXEC : FETCH;
            EXEC: begin
                if (isMemOp(F[3:0])) begin
                    stateNext = Mem_rdy ? FETCH : EXEC;
                end else if (F[3:0] == OP_STP) begin
                    stateNext = HALT;
                end else begin
                    stateNext = FETCH;
                end
            end
            HALT:    stateNext = HALT;
            default: stateNext = FETCH;
        endcase
    end

    mu0_decode #(
        .OPW(OPW)
    ) decodeInst (
        .Reset   (Reset),
        .state   (state),
        .F       (F),
        .N       (N),
        .Z       (Z),
        .Mem_rdy (Mem_rdy),
        .X_sel   (X_sel),
        .Y_sel   (Y_sel),
        .Addr_sel(Addr_sel),
        .ALU_fs  (ALU_fs),
        .PC_En   (PC_En),
        .IR_En   (IR_En),
        .Acc_En  (Acc_En),
        .Mem_req (Mem_req),
        .Mem_wr  (Mem_wr),
        .Halted  (Halted)
    );

endmodule

// File: tb/tb_mu0_control.sv
// Scoreboard bench for mu0_control: each driven cycle queues its hand-computed
// control word, and a negedge monitor compares the DUT outputs against it.
module tb_mu0_control;

    logic       Clk;
    logic       Reset;
    logic [3:0] F;
    logic       N;
    logic       Z;
    logic       Mem_rdy;
    logic       X_sel;
    logic       Y_sel;
    logic       Addr_sel;
    logic [1:0] ALU_fs;
    logic       PC_En;
    logic       IR_En;
    logic       Acc_En;
    logic       Mem_req;
    logic       Mem_wr;
    logic       Halted;

    // Control word layout: {X_sel, Y_sel, Addr_sel, ALU_fs, PC_En, IR_En, Acc_En, Mem_req, Mem_wr, Halted}
    localparam logic [10:0] V_RESET      = 11'b0_0_0_00_0_0_0_0_0_0;
    localparam logic [10:0] V_FETCH_RDY  = 11'b1_0_0_10_1_1_0_1_0_0;
    localparam logic [10:0] V_FETCH_WAIT = 11'b1_0_0_10_0_0_0_1_0_0;
    localparam logic [10:0] V_LDA_WAIT   = 11'b0_0_1_00_0_0_0_1_0_0;
    localparam logic [10:0] V_LDA_RDY    = 11'b0_0_1_00_0_0_1_1_0_0;
    localparam logic [10:0] V_ADD_WAIT   = 11'b0_0_1_01_0_0_0_1_0_0;
    localparam logic [10:0] V_ADD_RDY    = 11'b0_0_1_01_0_0_1_1_0_0;
    localparam logic [10:0] V_SUB_RDY    = 11'b0_0_1_11_0_0_1_1_0_0;
    localparam logic [10:0] V_STO        = 11'b0_0_1_00_0_0_0_1_1_0;
    localparam logic [10:0] V_JUMP       = 11'b0_1_0_00_1_0_0_0_0_0;
    localparam logic [10:0] V_IDLE       = 11'b0_0_0_00_0_0_0_0_0_0;
    localparam logic [10:0] V_HALT       = 11'b0_0_0_00_0_0_0_0_0_1;

    typedef struct {
        logic [10:0] expected;
        string       name;
    } expItemT;

    expItemT expQ[$];
    int      checkCount;
    int      passCount;

    mu0_control #(
        .OPW(4)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .F       (F),
        .N       (N),
        .Z       (Z),
        .Mem_rdy (Mem_rdy),
        .X_sel   (X_sel),
        .Y_sel   (Y_sel),
        .Addr_sel(Addr_sel),
        .ALU_fs  (ALU_fs),
        .PC_En   (PC_En),
        .IR_En   (IR_En),
        .Acc_En  (Acc_En),
        .Mem_req (Mem_req),
        .Mem_wr  (Mem_wr),
        .Halted  (Halted)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic applyStimulus(input logic rst, input logic [3:0] op, input logic n,
                                 input logic z, input logic rdy,
                                 input logic [10:0] expected, input string name);
        expItemT item;
        @(posedge Clk);
        #1;
        Reset   = rst;
        F       = op;
        N       = n;
        Z       = z;
        Mem_rdy = rdy;
        item.expected = expected;
        item.name     = name;
        expQ.push_back(item);
    endtask

    task automatic checkOutput(input expItemT item);
        logic [10:0] actual;
        actual = {X_sel, Y_sel, Addr_sel, ALU_fs, PC_En, IR_En, Acc_En, Mem_req, Mem_wr, Halted};
        checkCount++;
        if (actual === item.expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %b expected %b", item.name, actual, item.expected);
        end
    endtask

    always @(negedge Clk) begin
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checkCount = 0;
        passCount  = 0;
        Reset      = 1'b1;
        F          = 4'd0;
        N          = 1'b0;
        Z          = 1'b0;
        Mem_rdy    = 1'b1;

        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, V_RESET, "reset_c1");
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, V_RESET, "reset_c2");
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, V_FETCH_RDY, "fetch_first");

        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, V_LDA_WAIT, "lda_wait1");
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, V_LDA_WAIT, "lda_wait2");
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, V_LDA_WAIT, "lda_wait3");
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, V_LDA_RDY, "lda_done");

        applyStimulus(1'b0, 4'd5, 1'b1, 1'b0, 1'b0, V_FETCH_WAIT, "fetch_wait");
        applyStimulus(1'b0, 4'd5, 1'b1, 1'b0, 1'b1, V_FETCH_RDY, "fetch_jge_n1");
        applyStimulus(1'b0, 4'd5, 1'b1, 1'b0, 1'b1, V_IDLE, "jge_not_taken");
        applyStimulus(1'b0, 4'd5, 1'b0, 1'b0, 1'b1, V_FETCH_RDY, "fetch_jge_n0");
        applyStimulus(1'b0, 4'd5, 1'b0, 1'b0, 1'b0, V_JUMP, "jge_taken");

        applyStimulus(1'b0, 4'd6, 1'b0, 1'b1, 1'b1, V_FETCH_RDY, "fetch_jne_z1");
        applyStimulus(1'b0, 4'd6, 1'b0, 1'b1, 1'b1, V_IDLE, "jne_not_taken");
        applyStimulus(1'b0, 4'd6, 1'b1, 1'b0, 1'b1, V_FETCH_RDY, "fetch_jne_z0");
        applyStimulus(1'b0, 4'd6, 1'b1, 1'b0, 1'b1, V_JUMP, "jne_taken");

        applyStimulus(1'b0, 4'd4, 1'b1, 1'b1, 1'b1, V_FETCH_RDY, "fetch_jmp");
        applyStimulus(1'b0, 4'd4, 1'b1, 1'b1, 1'b0, V_JUMP, "jmp");

        applyStimulus(1'b0, 4'd1, 1'b0, 1'b0, 1'b1, V_FETCH_RDY, "fetch_sto");
        applyStimulus(1'b0, 4'd1, 1'b0, 1'b0, 1'b0, V_STO, "sto_wait");
        applyStimulus(1'b0, 4'd1, 1'b0, 1'b0, 1'b1, V_STO, "sto_done");

        applyStimulus(1'b0, 4'd3, 1'b0, 1'b0, 1'b1, V_FETCH_RDY, "fetch_sub");
        applyStimulus(1'b0, 4'd3, 1'b0, 1'b0, 1'b1, V_SUB_RDY, "sub_done");

        applyStimulus(1'b0, 4'd9, 1'b0, 1'b0, 1'b1, V_FETCH_RDY, "fetch_nop");
        applyStimulus(1'b0, 4'd9, 1'b0, 1'b0, 1'b0, V_IDLE, "nop");

        applyStimulus(1'b0, 4'd7, 1'b0, 1'b0, 1'b1, V_FETCH_RDY, "fetch_stp");
        applyStimulus(1'b0, 4'd7, 1'b0, 1'b0, 1'b1, V_IDLE, "stp");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 4'(i), 1'b0, 1'b0, 1'(i % 2), V_HALT, "halt_hold");
        end

        applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b1, V_RESET, "reset_from_halt");
        applyStimulus(1'b0, 4'd2, 1'b0, 1'b0, 1'b1, V_FETCH_RDY, "fetch_after_halt");
        applyStimulus(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, V_ADD_WAIT, "add_wait1");
        applyStimulus(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, V_ADD_WAIT, "add_wait2");
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b1, V_RESET, "reset_mid_add");
        applyStimulus(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, V_FETCH_WAIT, "fetch_after_abort");
        applyStimulus(1'b0, 4'd2, 1'b0, 1'b0, 1'b1, V_FETCH_RDY, "fetch_add");
        applyStimulus(1'b0, 4'd2, 1'b0, 1'b0, 1'b1, V_ADD_RDY, "add_done");

        @(negedge Clk);
        #1;
        checkCount++;
        if (expQ.size() == 0) begin
            passCount++;
        end else begin
            $display("[TB] FAIL queue_drain: got %0d pending expected 0", expQ.size());
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
